// File: rtl/wave_capture_if.sv
// Sample-in / waveform-RAM-out bundle for wave_capture.
// slave: the capture block; master: whatever drives samples and consumes writes.
interface wave_capture_if;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Triggered waveform capture into a double-buffered 512-entry RAM.
// Waits for a positive-going crossing of TRIG_THRESH, writes the next 256
// accepted samples (offset-binary, top byte) into the half not being shown,
// then swaps halves on the next rising edge of wave_display_idle.
// Optional macro WAVE_CAPTURE_DECIMATE_EN: accept every second sample while
// capturing, so one capture spans 512 input samples.
module wave_capture #(
  parameter logic signed [15:0] TRIG_THRESH = 16'sd0
) (
  input  logic          clk,
  input  logic          reset,
  wave_capture_if.slave bus
);

  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         count_q, count_d;
  logic signed [15:0] prev_q, prev_d;
  logic               idle_q;
  logic               rd_q, rd_d;
  logic               we_q, we_d;
  logic [8:0]         addr_q, addr_d;
  logic [7:0]         wsamp_q, wsamp_d;

  logic strobe;
  logic crossing;
  logic idle_rise;
  logic accept;

  assign strobe    = bus.new_sample_ready;
  assign crossing  = strobe && (prev_q < TRIG_THRESH) &&
                     ($signed(bus.new_sample_in) >= TRIG_THRESH);
  assign idle_rise = bus.wave_display_idle && !idle_q;

`ifdef WAVE_CAPTURE_DECIMATE_EN
  logic phase_q, phase_d;
  assign accept = (state_q == ACTIVE) && strobe && !phase_q;
`else
  assign accept = (state_q == ACTIVE) && strobe;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARMED;
      count_q <= '0;
      prev_q  <= '0;
      idle_q  <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wsamp_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prev_q  <= prev_d;
      idle_q  <= bus.wave_display_idle;
      rd_q    <= rd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wsamp_q <= wsamp_d;
    end
  end

`ifdef WAVE_CAPTURE_DECIMATE_EN
  // Decimation phase: cleared on trigger, toggled by every capture-time strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= 1'b0;
    else        phase_q <= phase_d;
  end
`endif

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:   if (crossing) state_d = ACTIVE;
      ACTIVE:  if (accept && (count_q == 8'd255)) state_d = WAIT;
      WAIT:    if (idle_rise) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  // Datapath and registered RAM-write outputs
  always_comb begin
    count_d = count_q;
    prev_d  = strobe ? $signed(bus.new_sample_in) : prev_q;
    rd_d    = rd_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wsamp_d = wsamp_q;
`ifdef WAVE_CAPTURE_DECIMATE_EN
    phase_d = phase_q;
    if (state_q == ACTIVE && strobe) phase_d = !phase_q;
    if (state_q == ARMED && crossing) phase_d = 1'b0;
`endif
    if (state_q == ARMED && crossing) count_d = '0;
    if (accept) begin
      // count wraps 255 -> 0 on the final write, ready for the next capture
      count_d = count_q + 8'd1;
      we_d    = 1'b1;
      addr_d  = {~rd_q, count_q};
      wsamp_d = bus.new_sample_in[15:8] + 8'd128;
    end
    if (state_q == WAIT && idle_rise) rd_d = !rd_q;
  end

  assign bus.write_address = addr_q;
  assign bus.write_enable  = we_q;
  assign bus.write_sample  = wsamp_q;
  assign bus.read_index    = rd_q;

endmodule

// File: tb/tb_wave_capture.sv
// Randomized scoreboard bench for wave_capture.
module tb_wave_capture;

  localparam logic signed [15:0] TH = 16'sd0;

  logic clk;
  logic rst_n;
  wave_capture_if bus_if ();

  wave_capture #(.TRIG_THRESH(TH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {M_ARMED, M_ACTIVE, M_WAIT} mmode_t;
  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t    exp_q[$];
  mmode_t m_mode;
  int     m_prev;
  bit     m_idle_prev;
  bit     m_rd;
  int     m_n;
  bit     m_phase;
  int     errors = 0;
  int     checks = 0;
  int     dut_writes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_ARMED;
    m_prev = 0;
    m_idle_prev = 1'b0;
    m_rd = 1'b0;
    m_n = 0;
    m_phase = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the model predicts the effect of the next rising edge
  task automatic step(input bit rdy, input logic [15:0] s, input bit idle);
    int  sv;
    bit  rise;
    bit  take;
    wr_t w;
    @(negedge clk);
    bus_if.new_sample_ready  = rdy;
    bus_if.new_sample_in     = s;
    bus_if.wave_display_idle = idle;
    sv   = int'($signed(s));
    rise = idle && !m_idle_prev;
    if (m_mode == M_WAIT && rise) begin
      m_rd   = !m_rd;
      m_mode = M_ARMED;
    end else if (rdy) begin
      if (m_mode == M_ARMED) begin
        if (m_prev < int'(TH) && sv >= int'(TH)) begin
          m_mode  = M_ACTIVE;
          m_n     = 0;
          m_phase = 1'b0;
        end
      end else if (m_mode == M_ACTIVE) begin
        take = 1'b1;
`ifdef WAVE_CAPTURE_DECIMATE_EN
        take    = !m_phase;
        m_phase = !m_phase;
`endif
        if (take) begin
          w.a = 9'((m_rd ? 0 : 256) + m_n);
          w.d = 8'(((sv >>> 8) + 128) % 256);
          exp_q.push_back(w);
          m_n++;
          if (m_n == 256) m_mode = M_WAIT;
        end
      end
    end
    if (rdy) m_prev = sv;
    m_idle_prev = idle;
  endtask

  task automatic apply_reset(input int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.new_sample_ready  = 1'b0;
    bus_if.wave_display_idle = 1'b0;
    model_reset();
    #1;
    chk("rst_write_enable", int'(bus_if.write_enable), 0);
    chk("rst_write_address", int'(bus_if.write_address), 0);
    chk("rst_write_sample", int'(bus_if.write_sample), 0);
    chk("rst_read_index", int'(bus_if.read_index), 0);
    repeat (ncyc) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every write must match the next queued expectation, one cycle after its strobe
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.write_enable) begin
        dut_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                   bus_if.write_address, bus_if.write_sample);
        end else begin
          e = exp_q.pop_front();
          chk("write_address", int'(bus_if.write_address), int'(e.a));
          chk("write_sample", int'(bus_if.write_sample), int'(e.d));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: got no write expected addr 0x%0h data 0x%0h", e.a, e.d);
      end
      chk("read_index", int'(bus_if.read_index), int'(m_rd));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic fill_capture(input bit idle, input int stop_at);
    int guard = 0;
    while (m_mode == M_ACTIVE && m_n < stop_at && guard < 8000) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), idle);
      guard++;
    end
    chk("capture_progress_bound", int'(guard < 8000), 1);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    bus_if.new_sample_ready  = 1'b0;
    bus_if.new_sample_in     = '0;
    bus_if.wave_display_idle = 1'b0;
    model_reset();
    apply_reset(3);
    repeat (2) step(1'b0, 16'h0, 1'b0);

    // Trigger on -5 -> +3, then first write of 16'h1234
    step(1'b1, 16'hFFFB, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0003, 1'b0);
    w0 = dut_writes;
    step(1'b1, 16'h1234, 1'b0);
    @(posedge clk); #2;
    chk("first_write_enable", int'(bus_if.write_enable), 1);
    chk("first_write_address", int'(bus_if.write_address), 'h100);
    chk("first_write_sample", int'(bus_if.write_sample), 'h92);
    chk("trigger_sample_not_written", dut_writes - w0, 1);

    // Extremes of the sample range
`ifdef WAVE_CAPTURE_DECIMATE_EN
    step(1'b1, 16'h0100, 1'b0);
`endif
    step(1'b1, 16'h8000, 1'b0);
    @(posedge clk); #2;
    chk("min_write_sample", int'(bus_if.write_sample), 'h00);
`ifdef WAVE_CAPTURE_DECIMATE_EN
    step(1'b1, 16'h0100, 1'b0);
`endif
    step(1'b1, 16'h7FFF, 1'b0);
    @(posedge clk); #2;
    chk("max_write_sample", int'(bus_if.write_sample), 'hFF);

    // Finish capture with idle raised long before WAIT entry
    fill_capture(1'b0, 200);
    fill_capture(1'b1, 256);
    repeat (3) step(1'b0, 16'h0, 1'b1);
    chk("capture_write_count", dut_writes - w0, 256);

    // Strobe 257 and further WAIT-time samples produce nothing
    step(1'b1, 16'h4000, 1'b1);
    step(1'b1, 16'hFF9C, 1'b1);
    repeat (3) step(1'b0, 16'h0, 1'b1);
    chk("no_flip_on_held_idle", int'(bus_if.read_index), 0);

    // Idle falls then rises with a would-be crossing strobe in the same cycle
    repeat (2) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'd500, 1'b1);
    @(posedge clk); #2;
    chk("flip_read_index", int'(bus_if.read_index), 1);

    // Non-crossing stream stays armed
    for (int i = 0; i < 30; i++) step(1'b1, 16'($urandom_range(0, 32767)), 1'b1);

    // Second capture targets the lower half; reset after 100 writes
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'h002A, 1'b0);
    fill_capture(1'b0, 100);
    step(1'b0, 16'h0, 1'b0);
    apply_reset(2);
    w0 = dut_writes;
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 32767)), 1'($urandom_range(0, 1)));
    chk("no_write_after_reset", dut_writes - w0, 0);

    // Fresh crossing after reset starts a full capture again
    step(1'b1, 16'h8001, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    w0 = dut_writes;
    fill_capture(1'b0, 256);
    repeat (3) step(1'b0, 16'h0, 1'b0);
    chk("recapture_write_count", dut_writes - w0, 256);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
